// File: rtl/alu_xor_arbiter.sv
// ============================================================================
// Module   : alu_xor_arbiter
// Brief    : Round-robin arbiter that feeds NREQ requesters into one shared
//            XOR unit, with a single-entry result register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_xor_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_HOLD = 1'b1;

    logic [0:0]       r_state;
    logic [IDW-1:0]   r_ptr;
    logic [WIDTH-1:0] r_data;
    logic [IDW-1:0]   r_id;

    logic             w_slot;
    logic             w_found;
    logic [IDW-1:0]   w_win;
    logic [NREQ-1:0]  w_ready;
    logic             w_fire;
    logic [WIDTH-1:0] w_xor;
    logic [IDW-1:0]   w_ptr_next;

    // rst_n is folded in so req_ready stays low for the whole reset window.
    assign w_slot = rst_n && ((r_state == c_IDLE) || rsp_ready);

    // Search starts at the pointer and wraps modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_win   = IDW'(idx);
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_slot && w_found) w_ready[w_win] = 1'b1;
    end

    assign w_fire     = w_slot && w_found;
    assign w_xor      = req_a[w_win*WIDTH +: WIDTH] ^ req_b[w_win*WIDTH +: WIDTH];
    assign w_ptr_next = (int'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_ptr   <= '0;
            r_data  <= '0;
            r_id    <= '0;
        end else if (w_fire) begin
            r_state <= c_HOLD;
            r_ptr   <= w_ptr_next;
            r_data  <= w_xor;
            r_id    <= w_win;
        end else if ((r_state == c_HOLD) && rsp_ready) begin
            r_state <= c_IDLE;
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = (r_state == c_HOLD);
    assign rsp_data  = r_data;
    assign rsp_id    = r_id;

endmodule

`default_nettype wire

// File: tb/tb_alu_xor_arbiter.sv
// ============================================================================
// Module   : tb_alu_xor_arbiter
// Brief    : Self-checking bench for alu_xor_arbiter (vector table plus
//            scoreboard-driven corner-case sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_xor_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_data;
    logic [1:0]   rsp_id;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  er;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ed;
    } vec_t;
    vec_t tbl[7];

    alu_xor_arbiter #(.WIDTH(32), .NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    // Owner lane carries the operand; every other lane carries its complement.
    function automatic logic [127:0] lanes(input logic [31:0] own, input logic [1:0] id);
        logic [127:0] r;
        for (int j = 0; j < 4; j++) r[j*32 +: 32] = (2'(j) == id) ? own : ~own;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cycle(input logic [3:0] v, input logic [127:0] a, input logic [127:0] b,
                         input logic rr, input logic [3:0] er, input logic [31:0] ed);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
        if (rsp_valid && q.size() != 0) begin
            chk("rsp_data", rsp_data, q[0].data);
            chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
            if (rr) void'(q.pop_front());
        end
        if (er != 4'b0) q.push_back('{id: oh2idx(er), data: ed});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = 4'hF;
        req_a     = '1;
        req_b     = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        q.delete();
        req_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] fa, fb, ln;
        logic [1:0]   id;

        tbl[0] = '{v: 4'b0001, er: 4'b0001, a: 32'hFFFF0000, b: 32'h0F0F0F0F, ed: 32'hF0F00F0F};
        tbl[1] = '{v: 4'b0000, er: 4'b0000, a: 32'h0,        b: 32'h0,        ed: 32'h0};
        tbl[2] = '{v: 4'b0100, er: 4'b0100, a: 32'hA5A5A5A5, b: 32'hA5A5A5A5, ed: 32'h00000000};
        tbl[3] = '{v: 4'b1000, er: 4'b1000, a: 32'hFFFFFFFF, b: 32'h00000000, ed: 32'hFFFFFFFF};
        tbl[4] = '{v: 4'b0110, er: 4'b0010, a: 32'h12345678, b: 32'h87654321, ed: 32'h95511559};
        tbl[5] = '{v: 4'b0011, er: 4'b0001, a: 32'hDEADBEEF, b: 32'h00000000, ed: 32'hDEADBEEF};
        tbl[6] = '{v: 4'b0000, er: 4'b0000, a: 32'h0,        b: 32'h0,        ed: 32'h0};

        do_reset();

        for (int i = 0; i < 7; i++) begin
            id = oh2idx(tbl[i].er);
            cycle(tbl[i].v, lanes(tbl[i].a, id), lanes(tbl[i].b, id), 1'b1, tbl[i].er, tbl[i].ed);
        end

        // Fairness from a fresh pointer: 0,1,2,3,0 with no bubbles.
        do_reset();
        for (int j = 0; j < 4; j++) begin
            fa[j*32 +: 32] = 32'h11111111 * (j + 1);
            fb[j*32 +: 32] = 32'(j) << 8;
        end
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % 4;
            cycle(4'b1111, fa, fb, 1'b1, 4'(1 << g), fa[g*32 +: 32] ^ fb[g*32 +: 32]);
        end
        cycle(4'b0000, fa, fb, 1'b1, 4'b0000, 32'h0);

        // Backpressure: pointer is 1, so requester 2 wins; hold for 5 cycles.
        cycle(4'b0100, fa, fb, 1'b1, 4'b0100, fa[64 +: 32] ^ fb[64 +: 32]);
        for (int k = 0; k < 5; k++) begin
            ln = fa ^ {4{32'(k) * 32'h01010101 + 32'h5}};
            cycle(4'b1111, ln, fb, 1'b0, 4'b0000, 32'h0);
        end
        cycle(4'b1111, fa, fb, 1'b1, 4'b1000, fa[96 +: 32] ^ fb[96 +: 32]);
        cycle(4'b0000, fa, fb, 1'b1, 4'b0000, 32'h0);

        // Wrap/skip: grant 2 leaves pointer at 3, then 0 and 1 win in turn.
        cycle(4'b0100, fa, fb, 1'b1, 4'b0100, fa[64 +: 32] ^ fb[64 +: 32]);
        cycle(4'b0011, fa, fb, 1'b1, 4'b0001, fa[0 +: 32] ^ fb[0 +: 32]);
        cycle(4'b0011, fa, fb, 1'b1, 4'b0010, fa[32 +: 32] ^ fb[32 +: 32]);
        cycle(4'b0000, fa, fb, 1'b1, 4'b0000, 32'h0);

        // Reset asserted mid-cycle while a result is held.
        cycle(4'b0001, fa, fb, 1'b0, 4'b0001, fa[0 +: 32] ^ fb[0 +: 32]);
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        req_valid = 4'hF;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_data", rsp_data, 32'd0);
        chk("async_rst_ready", 32'(req_ready), 32'd0);
        q.delete();
        req_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(4'b1100, fa, fb, 1'b1, 4'b0100, fa[64 +: 32] ^ fb[64 +: 32]);
        cycle(4'b0000, fa, fb, 1'b1, 4'b0000, 32'h0);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_xor_arbiter.md
ALU_XOR_ARBITER -- requirements
Module: alu_xor_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter NREQ, default 4, number of requesters; legal range 2..8.
REQ-003 Parameter IDW, default 2, requester-ID width; SHALL equal clog2(NREQ).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  NREQ  per-requester operation request.
REQ-007 req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-008 req_a  input  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
REQ-009 req_b  input  NREQ*WIDTH  operand B, same packing as req_a.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  downstream accepts result.
REQ-012 rsp_data  output  WIDTH  bitwise XOR result.
REQ-013 rsp_id  output  IDW  index of the requester that owns rsp_data.

Function
REQ-014 Shared datapath: one WIDTH-bit bitwise XOR unit; rsp_data[k] = A[k] ^ B[k] for every bit k, no carries or sign handling.
REQ-015 FSM has two states: IDLE (result register empty) and HOLD (result register full, rsp_valid=1).
REQ-016 Accept slot exists when state=IDLE, or state=HOLD and rsp_ready=1 in the same cycle.
REQ-017 In an accept slot with any req_valid high, exactly one winner w is chosen by round-robin; req_ready[w]=1 combinationally in that cycle; all other req_ready bits 0.
REQ-018 req_ready SHALL be 0 for all requesters outside an accept slot and when no req_valid is high.
REQ-019 Handshake on requester i completes when req_valid[i]=1 and req_ready[i]=1; at that edge req_a^req_b of i is registered into rsp_data, i into rsp_id, and state goes to HOLD.
REQ-020 Latency: handshake at edge N gives rsp_valid=1 in the cycle after edge N; throughput one op per cycle when rsp_ready stays 1.
REQ-021 HOLD with rsp_ready=0: rsp_valid, rsp_data, rsp_id held stable; no new accept.
REQ-022 HOLD with rsp_ready=1 and no req_valid: state goes to IDLE, rsp_valid=0 next cycle.
REQ-023 HOLD with rsp_ready=1 and a winner: response retired and new op loaded on the same edge; state stays HOLD (back-to-back, no bubble).
REQ-024 Round-robin: pointer p holds the highest-priority index; search order p, p+1, ..., wrapping modulo NREQ; after a grant to w, p becomes (w+1) mod NREQ.
REQ-025 Pointer wrap: grant to NREQ-1 sets p to 0.
REQ-026 Pointer unchanged in cycles without a handshake.
REQ-027 A requester that drops req_valid before being granted loses no state; arbitration re-evaluates every cycle.
REQ-028 Operands are sampled only at the handshake edge; later changes to req_a/req_b do not affect a held result.

Reset
REQ-029 While rst_n=0, outputs are immediate: state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, p=0, req_ready=0.
REQ-030 Reset asserted in HOLD discards the pending result with no response issued; the first post-reset grant goes to the lowest-indexed valid requester.
REQ-031 Deassertion of rst_n is synchronised externally; the block accepts requests from the first rising edge with rst_n=1.

Verification
REQ-032 Single op: req_valid=4'b0001, A=32'hFFFF0000, B=32'h0F0F0F0F, rsp_ready=1 -> one cycle later rsp_valid=1, rsp_data=32'hF0F00F0F, rsp_id=0.
REQ-033 Fairness: req_valid=4'b1111 held, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, rsp_valid continuously 1 after the first.
REQ-034 Backpressure: op loaded, rsp_ready=0 for 5 cycles while req_a changes -> rsp_data/rsp_id stable, req_ready=0 throughout; rsp_ready=1 retires it and accepts the next op on the same edge.
REQ-035 Wrap/skip: p=3 after grant to 2, req_valid=4'b0011 -> grant to 0, then 1.
REQ-036 Reset mid-op: rst_n=0 asynchronously while rsp_valid=1 -> rsp_valid=0 and rsp_data=0 immediately, before the next clock edge; after release req_valid=4'b1100 -> first grant to 2.
REQ-037 Boundary data: A=B=32'hA5A5A5A5 -> rsp_data=0; A=32'hFFFFFFFF, B=0 -> rsp_data=32'hFFFFFFFF.
